// File: rtl/bnn_window_mac_if.sv
// Window/weight/result bundle between the sliding-window stage, this MAC and the next BNN layer.
interface bnn_window_mac_if #(
    parameter int DATA_WIDTH = 6,
    parameter int K          = 3,
    parameter int LEN        = 9,
    parameter int ROWS       = 9,
    parameter int SUM_W      = DATA_WIDTH + $clog2(K*K) + 1
);
    logic                         ivalid;
    logic [K*K*DATA_WIDTH-1:0]    win;
    logic                         wload;
    logic [K*K-1:0]               wdata;
    logic signed [SUM_W-1:0]      thr;
    logic                         ovalid;
    logic signed [SUM_W-1:0]      osum;
    logic                         obit;
    logic [$clog2(LEN)-1:0]       ocol;
    logic [$clog2(ROWS)-1:0]      orow;
    logic                         busy;
    logic                         frame_done;

    modport master (
        output ivalid, win, wload, wdata, thr,
        input  ovalid, osum, obit, ocol, orow, busy, frame_done
    );

    modport slave (
        input  ivalid, win, wload, wdata, thr,
        output ovalid, osum, obit, ocol, orow, busy, frame_done
    );
endinterface

// File: rtl/bnn_window_mac.sv
// Binary-weighted 3x3 window MAC with raster tracking, thresholding and frame sequencing.
//   state | meaning
//   IDLE  | no frame in progress; weights may be loaded
//   RUN   | frame pixels arriving
//   DRAIN | last pixel accepted, waiting for its result to leave the pipeline
module bnn_window_mac #(
    parameter int DATA_WIDTH = 6,
    parameter int K          = 3,
    parameter int LEN        = 9,
    parameter int ROWS       = 9,
    parameter int SUM_W      = DATA_WIDTH + $clog2(K*K) + 1
) (
    input  logic           clk,
    input  logic           rstn,
    bnn_window_mac_if.slave bus
);
    localparam int N  = K*K;
    localparam int CW = $clog2(LEN);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           col;
    logic [RW-1:0]           row;
    logic                    last_px;
    logic [N-1:0]            wreg;

    logic                    pend, last_p;
    logic [CW-1:0]           ocol_p, ocol1;
    logic [RW-1:0]           orow_p, orow1;
    logic                    v1, last1;
    logic signed [SUM_W-1:0] term [N];
    logic signed [SUM_W-1:0] sum_c;

    assign last_px  = (col == CW'(LEN-1)) && (row == RW'(ROWS-1));
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.ivalid) state_nx = RUN;
            RUN:     if (bus.ivalid && last_px) state_nx = DRAIN;
            DRAIN: begin
                // a new frame may start before the previous one has drained
                if (bus.ivalid)          state_nx = RUN;
                else if (bus.frame_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wreg <= '0;
        end else if (bus.wload && state == IDLE) begin
            wreg <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            col <= '0;
            row <= '0;
        end else if (bus.ivalid) begin
            if (col == CW'(LEN-1)) begin
                col <= '0;
                row <= (row == RW'(ROWS-1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // qualify using the pre-increment position of the pixel being pushed
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend   <= 1'b0;
            last_p <= 1'b0;
            ocol_p <= '0;
            orow_p <= '0;
        end else begin
            pend <= bus.ivalid && (col >= CW'(K-1)) && (row >= RW'(K-1));
            if (bus.ivalid) begin
                ocol_p <= col - CW'(K-1);
                orow_p <= row - RW'(K-1);
                last_p <= last_px;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            ocol1 <= '0;
            orow1 <= '0;
            for (int i = 0; i < N; i++) term[i] <= '0;
        end else begin
            v1 <= pend;
            if (pend) begin
                last1 <= last_p;
                ocol1 <= ocol_p;
                orow1 <= orow_p;
                for (int i = 0; i < N; i++) begin
                    term[i] <= wreg[i]
                        ?   $signed({{(SUM_W-DATA_WIDTH){1'b0}}, bus.win[i*DATA_WIDTH +: DATA_WIDTH]})
                        : -($signed({{(SUM_W-DATA_WIDTH){1'b0}}, bus.win[i*DATA_WIDTH +: DATA_WIDTH]}));
                end
            end
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < N; i++) sum_c = sum_c + term[i];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            bus.ovalid     <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.osum       <= '0;
            bus.obit       <= 1'b0;
            bus.ocol       <= '0;
            bus.orow       <= '0;
        end else begin
            bus.ovalid     <= v1;
            bus.frame_done <= v1 && last1;
            if (v1) begin
                bus.osum <= sum_c;
                bus.obit <= (sum_c >= bus.thr);
                bus.ocol <= ocol1;
                bus.orow <= orow1;
            end
        end
    end
endmodule

// File: doc/bnn_window_mac.md
Name: bnn_window_mac

Overview:
- Consumes the 3x3 window bus from the line-buffer sliding stage and tracks raster position over an incoming frame.
- Computes the binary-weighted window sum for valid window positions only, i.e. windows that do not straddle a row edge or sit in the first K-1 rows.
- Binarizes each sum against a threshold and emits it to the next BNN layer.
- Sits directly downstream of the sliding-window stage, sharing its ivalid strobe.

Parameters:
- DATA_WIDTH, 6, unsigned activation width per pixel.
- K, 3, kernel size; window has K*K slices.
- LEN, 9, pixels per row (line length of the sliding stage).
- ROWS, 9, rows per frame.
- SUM_W, DATA_WIDTH+$clog2(K*K)+1, signed width of the window sum (11 at defaults).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- ivalid  in  1  pixel strobe, same signal that shifts the sliding stage.
- win  in  K*K*DATA_WIDTH  window bus. Slice i is at bits [i*DATA_WIDTH +: DATA_WIDTH]. Slice 0 is the top-left pixel (oldest); slices run left-to-right, then top-to-bottom; slice K*K-1 is the bottom-right pixel (newest).
- wload  in  1  weight load strobe.
- wdata  in  K*K  binary weights; bit i pairs with slice i; 1 means +x, 0 means -x.
- thr  in  SUM_W  signed threshold.
- ovalid  out  1  result valid, one-cycle pulse per window.
- osum  out  SUM_W  signed window sum.
- obit  out  1  1 when osum >= thr (signed compare).
- ocol  out  $clog2(LEN)  output-map column, i.e. pixel column minus (K-1).
- orow  out  $clog2(ROWS)  output-map row.
- busy  out  1  frame in progress or pipeline not drained.
- frame_done  out  1  one-cycle pulse coincident with the last ovalid of a frame.

Behaviour:
- Reset: while rstn is low at a clk edge, all outputs go to 0, col/row counters go to 0, pipeline valids are cleared, the weight register is cleared to 0, and the FSM enters IDLE. Reset applied mid-frame abandons the frame: no ovalid and no frame_done is emitted for it.
- Position counters:
  - On each ivalid, (col,row) describe the pixel being pushed.
  - col increments, wrapping LEN-1 -> 0; on that wrap row increments.
  - row wraps ROWS-1 -> 0 at the last pixel of the frame.
- Window qualification: at an ivalid edge, register pend = (col >= K-1) && (row >= K-1), using pre-increment counters. Also register ocol_p = col-(K-1), orow_p = row-(K-1), and last_p = (col==LEN-1 && row==ROWS-1).
- Pipeline, with pixel presented in cycle T:
  - T+1: win holds the window for that pixel. Stage 1 registers the K*K terms, each zero-extended to SUM_W and negated where the weight bit is 0. Gated by pend.
  - T+2: stage 2 registers the adder-tree sum plus the compare against thr.
  - T+3: ovalid=1, osum, obit, ocol, orow and frame_done (if last_p) are visible. Fixed latency is 3 cycles from the ivalid cycle.
  - Back-to-back ivalid gives one result per cycle with no bubbles. Gaps in ivalid produce matching gaps in ovalid.
- thr is sampled in stage 2.
- Arithmetic: sum range is +/- K*K*(2^DATA_WIDTH-1), i.e. +/-567 at defaults. No saturation is needed because SUM_W covers it.
- FSM:
  - IDLE -> RUN on first ivalid.
  - RUN -> DRAIN on the ivalid carrying the last pixel.
  - DRAIN -> IDLE the cycle after frame_done.
  - A new frame's ivalid in DRAIN is accepted (counters are already at 0) and the FSM goes directly to RUN.
  - busy = (state != IDLE).
- Weights: wload is honoured only when busy=0; wdata is latched at that edge. wload while busy=1 is ignored. Weights are therefore stable across a frame.
- Outputs hold their last values between ovalid pulses, except frame_done, which is a pulse.
- At defaults there are 49 results per frame, in raster order: (orow,ocol) from (0,0) to (6,6).

Test Plan:
- Reset, wload with wdata=9'h1FF, then 81 back-to-back pixels of value 1 -> 49 ovalid pulses, each osum=9; first ovalid arrives 3 cycles after pixel index 20; frame_done coincides with (orow,ocol)=(6,6).
- wdata=9'h000, all pixels 63, thr=0 -> every osum=-567, obit=0.
- wdata=9'h0F0 (mixed weights), pixel value = raster index mod 64, thr=10 -> osum/obit match a bench reference model. Check ocol resets to 0 at each row and that no output appears for pixel columns 0-1.
- ivalid toggled every other cycle -> ovalid also every other cycle; values identical to the back-to-back run.
- wload with 9'h000 during a frame -> ignored (results keep using the prior weights); the same wload after frame_done takes effect on the next frame.
- rstn asserted after pixel 40 and then 81 fresh pixels sent -> no stale ovalid; the new frame yields exactly 49 results starting at (0,0).
